// File: rtl/dmem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_ctrl
// Desc     : Single-outstanding load/store controller for a 32-bit
//            byte-maskable synchronous SRAM port. Handles lane steering,
//            alignment checking, and load sign/zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_port_ctrl #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] sram_a,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [3:0]        sram_bytemask,
    output logic [31:0]       sram_i,
    input  logic [31:0]       sram_o
);

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RD   = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [1:0]  w_off;
    logic        w_err;
    logic        w_accept;
    logic [3:0]  w_store_mask;
    logic [31:0] w_store_data;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;
    logic [31:0] r_resp_data;
    logic        r_resp_err;
    logic [31:0] w_shifted;
    logic [31:0] w_load_fmt;

    // Address split is purely combinational so the SRAM sees it in the accept cycle
    assign sram_a   = req_addr[ADDR_W+1:2];
    assign w_off    = req_addr[1:0];
    assign w_accept = req_valid && req_ready;

    // Illegal size, or half/word not naturally aligned
    assign w_err = (req_size == 2'b11)
                || ((req_size == c_SZ_HALF) && w_off[0])
                || ((req_size == c_SZ_WORD) && (w_off != 2'b00));

    // Store lane enables and replicated write data
    always_comb begin
        w_store_mask = 4'b1111;
        w_store_data = req_wdata;
        case (req_size)
            c_SZ_BYTE: begin
                w_store_mask = 4'b0001 << w_off;
                w_store_data = {4{req_wdata[7:0]}};
            end
            c_SZ_HALF: begin
                w_store_mask = 4'b0011 << w_off;
                w_store_data = {2{req_wdata[15:0]}};
            end
            default: begin
                w_store_mask = 4'b1111;
                w_store_data = req_wdata;
            end
        endcase
    end

    // Load formatting: align the addressed lane to bit 0, then extend
    always_comb begin
        w_shifted  = sram_o >> {r_off, 3'b000};
        w_load_fmt = w_shifted;
        case (r_size)
            c_SZ_BYTE: w_load_fmt = {{24{~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            c_SZ_HALF: w_load_fmt = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default:   w_load_fmt = w_shifted;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and SRAM strobes; everything idles while reset is high
    always_comb begin
        w_next_state  = r_state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        sram_csb      = 1'b1;
        sram_web      = 1'b1;
        sram_oeb      = 1'b1;
        sram_bytemask = 4'b0000;
        sram_i        = 32'h0;
        if (!reset) begin
            case (r_state)
                c_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        if (w_err) begin
                            w_next_state = c_RESP;
                        end else if (req_we) begin
                            w_next_state  = c_RESP;
                            sram_csb      = 1'b0;
                            sram_web      = 1'b0;
                            sram_bytemask = w_store_mask;
                            sram_i        = w_store_data;
                        end else begin
                            w_next_state = c_RD;
                            sram_csb     = 1'b0;
                            sram_oeb     = 1'b0;
                        end
                    end
                end
                c_RD: begin
                    sram_oeb     = 1'b0;
                    w_next_state = c_RESP;
                end
                c_RESP: begin
                    resp_valid = 1'b1;
                    if (resp_ready) begin
                        w_next_state = c_IDLE;
                    end
                end
                default: w_next_state = c_IDLE;
            endcase
        end
    end

    // Request attributes for the read phase and the held response payload
    always_ff @(posedge clk) begin
        if (reset) begin
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_off       <= 2'b00;
            r_resp_data <= 32'h0;
            r_resp_err  <= 1'b0;
        end else if (w_accept) begin
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_off       <= w_off;
            r_resp_data <= 32'h0;
            r_resp_err  <= w_err;
        end else if (r_state == c_RD) begin
            r_resp_data <= w_load_fmt;
            r_resp_err  <= 1'b0;
        end
    end

    assign resp_data = reset ? 32'h0 : r_resp_data;
    assign resp_err  = reset ? 1'b0  : r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_port_ctrl
// Desc     : Self-checking bench for dmem_port_ctrl: SRAM device model,
//            transaction-level reference model, directed and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_port_ctrl;

    localparam int ADDR_W = 7;
    localparam int AW2    = ADDR_W + 2;
    localparam int NWORDS = 1 << ADDR_W;
    localparam int NBYTES = NWORDS * 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [AW2-1:0]    req_addr = '0;
    logic [31:0]       req_wdata = 32'h0;
    logic              resp_ready = 1'b1;
    logic              req_ready;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic [ADDR_W-1:0] sram_a;
    logic              sram_csb;
    logic              sram_web;
    logic              sram_oeb;
    logic [3:0]        sram_bytemask;
    logic [31:0]       sram_i;
    logic [31:0]       sram_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_port_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .sram_a       (sram_a),
        .sram_csb     (sram_csb),
        .sram_web     (sram_web),
        .sram_oeb     (sram_oeb),
        .sram_bytemask(sram_bytemask),
        .sram_i       (sram_i),
        .sram_o       (sram_o)
    );

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", name, got, exp, $time);
        end
    endfunction

    function automatic logic [31:0] init_word(int w);
        logic [31:0] k;
        k = 32'(w + 1);
        return (k * 32'h9E3779B9) ^ 32'h5A5AA5A5;
    endfunction

    // SRAM device: CE edge latches the access, read data appears after the edge
    logic [31:0] dev_mem [NWORDS];
    logic [31:0] dev_dout = 32'h0;
    bit          dev_init = 1'b0;
    assign sram_o = dev_dout;

    always @(posedge clk) begin
        if (!dev_init) begin
            for (int w = 0; w < NWORDS; w++) dev_mem[w] = init_word(w);
            dev_init = 1'b1;
        end
        if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < 4; b++)
                    if (sram_bytemask[b]) dev_mem[sram_a][8*b +: 8] = sram_i[8*b +: 8];
            end else begin
                dev_dout <= dev_mem[sram_a];
            end
        end
    end

    // Reference model: byte-addressed memory plus one outstanding transaction
    bit [7:0]    ref_mem [NBYTES];
    bit          ref_init  = 1'b0;
    int          cyc       = 0;
    bit          pend      = 1'b0;
    bit          pend_load = 1'b0;
    int          resp_at   = 0;
    logic [31:0] exp_data  = 32'h0;
    bit          exp_err   = 1'b0;

    function automatic int nbytes(logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_err(logic [1:0] s, logic [AW2-1:0] a);
        return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] model_load(logic [1:0] s, bit uns, logic [AW2-1:0] a);
        int n;
        logic [31:0] v;
        n = nbytes(s);
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
        if (n < 4 && !uns && v[8*n-1])
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] model_mask(logic [1:0] s, logic [AW2-1:0] a);
        logic [3:0] m;
        m = 4'b0000;
        for (int i = 0; i < nbytes(s); i++) m[(int'(a) + i) % 4] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(logic [1:0] s, logic [31:0] d);
        logic [31:0] v;
        v = d;
        if (s == 2'd0) for (int i = 0; i < 4; i++) v[8*i +: 8] = d[7:0];
        else if (s == 2'd1) for (int i = 0; i < 2; i++) v[16*i +: 16] = d[15:0];
        return v;
    endfunction

    // Advance the reference model on each clock edge
    always @(posedge clk) begin
        if (!ref_init) begin
            for (int w = 0; w < NWORDS; w++)
                for (int b = 0; b < 4; b++) ref_mem[4*w + b] = init_word(w) >> (8*b);
            ref_init = 1'b1;
        end
        if (reset) begin
            pend      = 1'b0;
            pend_load = 1'b0;
        end else if (pend) begin
            if (cyc >= resp_at && resp_ready) begin
                pend      = 1'b0;
                pend_load = 1'b0;
            end
        end else if (req_valid) begin
            pend = 1'b1;
            if (is_err(req_size, req_addr)) begin
                exp_err = 1'b1; exp_data = 32'h0; resp_at = cyc + 1; pend_load = 1'b0;
            end else if (req_we) begin
                exp_err = 1'b0; exp_data = 32'h0; resp_at = cyc + 1; pend_load = 1'b0;
                for (int i = 0; i < nbytes(req_size); i++)
                    ref_mem[int'(req_addr) + i] = req_wdata[8*i +: 8];
            end else begin
                exp_err = 1'b0; resp_at = cyc + 2; pend_load = 1'b1;
                exp_data = model_load(req_size, req_unsigned, req_addr);
            end
        end
        cyc++;
    end

    // Compare every DUT output against the model, mid-cycle
    always @(negedge clk) begin : cmp
        bit         acc, rd, vld, ok_req;
        logic       e_csb, e_web, e_oeb;
        logic [3:0] e_m;
        if (ref_init) begin
            acc    = !reset && !pend && req_valid;
            ok_req = acc && !is_err(req_size, req_addr);
            rd     = !reset && pend && pend_load && (cyc == resp_at - 1);
            vld    = !reset && pend && (cyc >= resp_at);
            chk("req_ready", req_ready, !reset && !pend);
            chk("resp_valid", resp_valid, vld);
            if (vld) begin
                chk("resp_data", resp_data, exp_data);
                chk("resp_err", resp_err, exp_err);
            end
            e_csb = 1'b1; e_web = 1'b1; e_oeb = 1'b1; e_m = 4'b0000;
            if (ok_req && req_we) begin
                e_csb = 1'b0; e_web = 1'b0; e_m = model_mask(req_size, req_addr);
            end else if (ok_req) begin
                e_csb = 1'b0; e_oeb = 1'b0;
            end else if (rd) begin
                e_oeb = 1'b0;
            end
            chk("sram_csb", sram_csb, e_csb);
            chk("sram_web", sram_web, e_web);
            chk("sram_oeb", sram_oeb, e_oeb);
            chk("sram_bytemask", sram_bytemask, e_m);
            if (ok_req) chk("sram_a", sram_a, req_addr[AW2-1:2]);
            if (ok_req && req_we) chk("sram_i", sram_i, model_wdata(req_size, req_wdata));
        end
    end

    // Offer one request now, then collect what the port did and its response
    task automatic xact_now(input bit we, input logic [1:0] sz, input bit uns,
                            input logic [AW2-1:0] addr, input logic [31:0] wd,
                            output logic [3:0] m, output logic [31:0] si,
                            output logic [ADDR_W-1:0] sa, output logic csb,
                            output logic [31:0] rdat, output logic er, output int lat);
        bit found;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(negedge clk);
        chk("dir_accept_ready", req_ready, 1);
        m = sram_bytemask; si = sram_i; sa = sram_a; csb = sram_csb;
        @(posedge clk); #1;
        req_valid = 1'b0;
        found = 1'b0; lat = 0; rdat = 32'h0; er = 1'b0;
        for (int k = 1; k <= 10 && !found; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                found = 1'b1; lat = k; rdat = resp_data; er = resp_err;
            end
        end
        if (!found) chk("dir_resp_timeout", 0, 1);
    endtask

    typedef struct {
        bit              we;
        logic [1:0]      sz;
        bit              uns;
        logic [AW2-1:0]  addr;
        logic [31:0]     wd;
        logic [3:0]      m;
        logic [31:0]     si;
        logic [ADDR_W-1:0] sa;
        bit              csb;
        logic [31:0]     rd;
        bit              er;
        int              lat;
    } dir_t;

    dir_t dirs[9];

    initial begin
        logic [3:0]        m;
        logic [31:0]       si, rdat;
        logic [ADDR_W-1:0] sa;
        logic              csb, er;
        int                lat;
        bit                found;

        dirs[0] = '{1, 2'd2, 0, 9'h010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 7'd4, 0, 32'h0,        0, 1};
        dirs[1] = '{0, 2'd2, 0, 9'h010, 32'h0,        4'h0, 32'h0,        7'd4, 0, 32'hDEADBEEF, 0, 2};
        dirs[2] = '{1, 2'd0, 0, 9'h013, 32'h12345680, 4'h8, 32'h80808080, 7'd4, 0, 32'h0,        0, 1};
        dirs[3] = '{0, 2'd0, 0, 9'h013, 32'h0,        4'h0, 32'h0,        7'd4, 0, 32'hFFFFFF80, 0, 2};
        dirs[4] = '{0, 2'd0, 1, 9'h013, 32'h0,        4'h0, 32'h0,        7'd4, 0, 32'h00000080, 0, 2};
        dirs[5] = '{1, 2'd1, 0, 9'h022, 32'hABCD1234, 4'hC, 32'h12341234, 7'd8, 0, 32'h0,        0, 1};
        dirs[6] = '{0, 2'd1, 0, 9'h022, 32'h0,        4'h0, 32'h0,        7'd8, 0, 32'h00001234, 0, 2};
        dirs[7] = '{0, 2'd1, 0, 9'h001, 32'h0,        4'h0, 32'h0,        7'd0, 1, 32'h0,        1, 1};
        dirs[8] = '{1, 2'd2, 0, 9'h006, 32'hCAFEF00D, 4'h0, 32'h0,        7'd1, 1, 32'h0,        1, 1};

        // Reset holds everything quiet even with a request offered
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 9'h010;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_csb", sram_csb, 1);
        chk("rst_web", sram_web, 1);
        chk("rst_oeb", sram_oeb, 1);
        chk("rst_mask", sram_bytemask, 0);

        // Directed table; the first request lands in the first cycle out of reset
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (i == 0) reset = 1'b0;
            xact_now(dirs[i].we, dirs[i].sz, dirs[i].uns, dirs[i].addr, dirs[i].wd,
                     m, si, sa, csb, rdat, er, lat);
            chk($sformatf("dir%0d_mask", i), m, dirs[i].m);
            chk($sformatf("dir%0d_addr", i), sa, dirs[i].sa);
            chk($sformatf("dir%0d_csb", i), csb, dirs[i].csb);
            if (dirs[i].we && !dirs[i].csb) chk($sformatf("dir%0d_wdata", i), si, dirs[i].si);
            chk($sformatf("dir%0d_data", i), rdat, dirs[i].rd);
            chk($sformatf("dir%0d_err", i), er, dirs[i].er);
            chk($sformatf("dir%0d_lat", i), lat, dirs[i].lat);
        end

        // Back-pressure: response must hold while the consumer stalls
        @(posedge clk); #1;
        resp_ready = 1'b0;
        xact_now(0, 2'd2, 0, 9'h010, 32'h0, m, si, sa, csb, rdat, er, lat);
        chk("bp_first_data", rdat, 32'h80ADBEEF);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", resp_valid, 1);
            chk("bp_data", resp_data, 32'h80ADBEEF);
            chk("bp_req_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", resp_valid, 1);
        @(negedge clk);
        chk("bp_after_valid", resp_valid, 0);
        chk("bp_after_ready", req_ready, 1);

        // Reset during the read phase drops the load entirely
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 9'h010;
        @(posedge clk); #1;
        req_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstrd_ready", req_ready, 1);
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) found = 1'b1;
        end
        chk("rstrd_no_resp", found, 0);

        // Random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset        = ($urandom_range(0, 199) == 0);
            req_valid    = 1'($urandom_range(0, 1));
            req_we       = 1'($urandom_range(0, 1));
            req_size     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            req_unsigned = 1'($urandom_range(0, 1));
            req_addr     = AW2'($urandom);
            if ($urandom_range(0, 1) == 1) req_addr[AW2-1:6] = '0;
            if ($urandom_range(0, 9) < 7) begin
                if (req_size == 2'd1) req_addr[0] = 1'b0;
                if (req_size == 2'd2) req_addr[1:0] = 2'b00;
            end
            req_wdata    = $urandom;
            resp_ready   = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_port_ctrl.md
DMEM_PORT_CTRL -- requirements
Module: dmem_port_ctrl

Interface
REQ-001 Parameter ADDR_W, default 7, word-address width of the attached SRAM2RW*x32M port (7 = 128 words).
REQ-002 clk  input  1  rising-edge clock; the same net drives the SRAM port's CE pin.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  request offered.
REQ-005 req_ready  output  1  controller can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0; ignored for stores.
REQ-009 req_addr  input  ADDR_W+2  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  consumer accepts the response.
REQ-013 resp_data  output  32  formatted load data; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned or illegal-size request.
REQ-015 sram_a  output  ADDR_W  word address; sram_csb, sram_web, sram_oeb  output  1 each  active-low chip-select, write-enable and output-enable; sram_bytemask  output  4  lane enables; sram_i  output  32  write data; sram_o  input  32  read data.

Function
REQ-016 FSM states: IDLE, RD, RESP; req_ready = (state==IDLE) && !reset.
REQ-017 A request is accepted in any cycle N with req_valid && req_ready.
REQ-018 In cycle N, sram_a = req_addr[ADDR_W+1:2] and off = req_addr[1:0], both derived combinationally.
REQ-019 Error condition: size 11; or half with off[0]=1; or word with off!=0.
REQ-020 Accepted erroneous request: sram_csb stays 1 and the FSM goes IDLE->RESP with resp_err=1 and resp_data=0.
REQ-021 Accepted store, cycle N: sram_csb=0, sram_web=0, sram_oeb=1.
REQ-022 Store lanes: sram_bytemask = 0001<<off for byte, 0011<<off for half, 1111 for word.
REQ-023 Store data: sram_i = {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, wdata for word.
REQ-024 Store completion: FSM goes IDLE->RESP, with resp_valid high from cycle N+1 and resp_data=0.
REQ-025 Accepted load, cycle N: sram_csb=0, sram_web=1, sram_bytemask=0000, sram_oeb=0; FSM goes IDLE->RD.
REQ-026 The controller registers size, unsigned and off for use in RD.
REQ-027 RD (cycle N+1): sram_oeb=0 and sram_csb=1.
REQ-028 At the end of RD, resp_data captures the formatted load data and the FSM goes RD->RESP, so resp_valid rises in cycle N+2.
REQ-029 Formatting: shift sram_o right by 8*off, then sign- or zero-extend from bit 7 (byte) or bit 15 (half); word data passes through.
REQ-030 RESP: resp_valid=1, with resp_data and resp_err held stable until resp_ready=1.
REQ-031 On the handshake the FSM goes RESP->IDLE and resp_valid drops the next cycle.
REQ-032 No request is accepted in RD or RESP; back-to-back throughput is one load per 3 cycles and one store per 2 cycles.
REQ-033 Outside the access cycles defined above: sram_csb=1, sram_web=1, sram_oeb=1 and sram_bytemask=0000.

Reset
REQ-034 While reset=1: state=IDLE, req_ready=0, resp_valid=0, resp_data=0, resp_err=0, sram_csb=1, sram_web=1, sram_oeb=1 and sram_bytemask=0000, regardless of req_valid.
REQ-035 Reset in RD or RESP discards the pending operation; no response is issued after reset deasserts.
REQ-036 The first request can be accepted in the first cycle with reset=0.

Verification
REQ-037 Word store then load: store addr 0x010 word 0xDEADBEEF -> bytemask 1111 and sram_a=4; load addr 0x010 -> resp_data=0xDEADBEEF at N+2, resp_err=0.
REQ-038 Byte store then signed/unsigned loads: store byte 0x80 to addr 0x013 -> bytemask 1000 and sram_i=0x80808080; signed byte load 0x013 -> 0xFFFFFF80; unsigned load -> 0x00000080.
REQ-039 Half store then signed load: store half 0x1234 to addr 0x022 -> bytemask 1100; signed half load 0x022 -> 0x00001234.
REQ-040 Misaligned load: half load at addr 0x001 -> sram_csb stays 1 and resp_err=1 with resp_data=0 at N+1; word store at 0x006 -> same error behaviour.
REQ-041 Back-pressure: resp_ready held 0 for 5 cycles after a load -> resp_valid and resp_data stable and req_ready=0 throughout; release -> IDLE next cycle.
REQ-042 Reset mid-load: assert reset in RD -> no resp_valid afterwards; req_ready=1 in the first cycle after reset deasserts.
